// File: rtl/addsub_serial_pkg.sv
// rtl/addsub_serial_pkg.sv - shared state/select encodings and full-adder cell for addsub_serial
package addsub_serial_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   // One-bit full-adder cell; returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational DIGIT-bit ripple adder built from the full-adder cell
module addsub_slice
   import addsub_serial_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic       c;
   logic [1:0] fa;

   // c_msb ends up as the carry entering the top bit of this digit.
   always_comb begin
      c     = ci;
      c_msb = ci;
      fa    = '0;
      s     = '0;
      for (int i = 0; i < DIGIT; i++) begin
         c_msb = c;
         fa    = full_add(x[i], y[i], c);
         s[i]  = fa[0];
         c     = fa[1];
      end
      co = c;
   end

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - multi-cycle digit-serial adder/subtractor with start/busy/done handshake
module addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSTEPS = WIDTH / DIGIT;
   localparam int CW     = $clog2(NSTEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("addsub_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   logic             state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] slice_s;
   logic             slice_co;
   logic             slice_cmsb;

   addsub_slice #(.DIGIT(DIGIT)) u_slice (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .ci    (carry_q),
      .s     (slice_s),
      .co    (slice_co),
      .c_msb (slice_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtraction runs as a + ~b + ~borrow through the same adder.
               a_d     = a;
               b_d     = (sel == SEL_ADD) ? b : ~b;
               carry_d = (sel == SEL_SUB) ^ cin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
            carry_d = slice_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // On the final digit the slice's top bit is the word's MSB.
               sum_d   = res_d;
               cout_d  = slice_co;
               ovf_d   = slice_co ^ slice_cmsb;
               zero_d  = (res_d == '0);
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
